// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter for the shared memory port (AXI write, AXI read, peripheral)
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W/8-1:0] wr_strb_i,
  output logic              wr_gnt_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_gnt_o,
  output logic              rd_rvalid_o,
  output logic [DATA_W-1:0] rd_rdata_o,
  input  logic              p_req_i,
  input  logic              p_op_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [DATA_W-1:0] p_wdata_i,
  output logic              p_gnt_o,
  output logic              p_rvalid_o,
  output logic [DATA_W-1:0] p_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);
  localparam int SW = DATA_W / 8;
  typedef enum logic [1:0] {ARB, ACCESS, RDATA} state_t;
  state_t state, state_n;
  logic [2:0] req;
  logic [1:0] rr_ptr, c1, c2, win, idx;
  logic any, acc, we, n_we;
  logic [ADDR_W-1:0] addr, n_addr;
  logic [DATA_W-1:0] wdata, n_wdata;
  logic [SW-1:0] strb, n_strb;
  // Round-robin pick, winner's command fields, next state and gated port outputs
  always_comb begin
    req = {p_req_i, rd_req_i, wr_req_i};
    any = |req;
    c1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    c2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    win = req[rr_ptr] ? rr_ptr : req[c1] ? c1 : c2;
    n_we = (win == 2'd0) ? 1'b1 : (win == 2'd1) ? 1'b0 : p_op_i;
    n_addr = (win == 2'd0) ? wr_addr_i : (win == 2'd1) ? rd_addr_i : p_addr_i;
    n_wdata = (win == 2'd0) ? wr_data_i : (win == 2'd2) ? p_wdata_i : '0;
    n_strb = (win == 2'd0) ? wr_strb_i : (win == 2'd2 && p_op_i) ? '1 : '0;
    state_n = (state == ARB) ? (any ? ACCESS : ARB) : (state == ACCESS && !we) ? RDATA : ARB;
    acc = (state == ACCESS) && !rst_i;
    wr_gnt_o = acc && idx == 2'd0;
    rd_gnt_o = acc && idx == 2'd1;
    p_gnt_o = acc && idx == 2'd2;
    mem_en_o = acc;
    mem_we_o = acc && we;
    mem_wstrb_o = acc ? strb : '0;
    mem_addr_o = addr;
    mem_wdata_o = wdata;
    busy_o = state != ARB;
  end
  // State register and round-robin pointer; the pointer moves past whoever was just served
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB;
      rr_ptr <= 2'd0;
    end else begin
      state <= state_n;
      if (state == ACCESS) rr_ptr <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end
  // Command register, loaded once per arbitration so later input changes cannot disturb the access
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx <= 2'd0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      strb <= '0;
    end else if (state == ARB && any) begin
      idx <= win;
      we <= n_we;
      addr <= n_addr;
      wdata <= n_wdata;
      strb <= n_strb;
    end
  end
  // Read return: capture memory data in RDATA and flag it valid for the following cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_rvalid_o <= 1'b0;
      p_rvalid_o <= 1'b0;
      rd_rdata_o <= '0;
      p_rdata_o <= '0;
    end else begin
      rd_rvalid_o <= state == RDATA && idx == 2'd1;
      p_rvalid_o <= state == RDATA && idx == 2'd2;
      if (state == RDATA && idx == 2'd1) rd_rdata_o <= mem_rdata_i;
      if (state == RDATA && idx == 2'd2) p_rdata_o <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a small behavioural memory
module tb_mem_port_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic wr_req_i = 0, rd_req_i = 0, p_req_i = 0, p_op_i = 0;
  logic [31:0] wr_addr_i = 0, wr_data_i = 0, rd_addr_i = 0, p_addr_i = 0, p_wdata_i = 0;
  logic [3:0] wr_strb_i = 0;
  logic wr_gnt_o, rd_gnt_o, rd_rvalid_o, p_gnt_o, p_rvalid_o, mem_en_o, mem_we_o, busy_o;
  logic [31:0] rd_rdata_o, p_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_wstrb_o;
  logic [31:0] mem [64] = '{default: '0};
  logic [31:0] mq = '0;
  typedef struct {int who; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;} g_t;
  typedef struct {int who; logic [31:0] data;} r_t;
  g_t gq[$];
  r_t rq[$];
  int n_chk = 0, n_fail = 0, cyc = 0, last_gnt = 0, last_rv = 0, gap_ref = -1, t0;
  bit hold = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o), .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
    .p_req_i(p_req_i), .p_op_i(p_op_i), .p_addr_i(p_addr_i), .p_wdata_i(p_wdata_i), .p_gnt_o(p_gnt_o),
    .p_rvalid_o(p_rvalid_o), .p_rdata_o(p_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  // Synchronous-read memory with byte strobes
  always @(posedge clk_i) begin
    if (mem_en_o && mem_we_o) begin
      for (int b = 0; b < 4; b++) if (mem_wstrb_o[b]) mem[mem_addr_o[7:2]][8*b+:8] <= mem_wdata_o[8*b+:8];
    end else if (mem_en_o) mq <= mem[mem_addr_o[7:2]];
  end
  assign mem_rdata_i = mq;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_g(input int who, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    g_t g;
    g = '{who, we, a, d, s};
    gq.push_back(g);
  endtask

  task automatic push_r(input int who, input logic [31:0] d);
    r_t r;
    r = '{who, d};
    rq.push_back(r);
  endtask

  task automatic req_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_addr_i = a; wr_data_i = d; wr_strb_i = s; wr_req_i = 1;
    push_g(0, 1'b1, a, d, s);
  endtask

  task automatic req_rd(input logic [31:0] a, input logic [31:0] exp);
    rd_addr_i = a; rd_req_i = 1;
    push_g(1, 1'b0, a, 32'h0, 4'h0);
    push_r(1, exp);
  endtask

  task automatic req_p(input logic op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    p_op_i = op; p_addr_i = a; p_wdata_i = d; p_req_i = 1;
    push_g(2, op, a, d, op ? 4'hF : 4'h0);
    if (!op) push_r(2, exp);
  endtask

  // One clock: sample just after the edge, score grants and read returns, release granted requests
  task automatic tick();
    int ng, nv, who;
    g_t g;
    r_t r;
    @(posedge clk_i);
    #1;
    cyc++;
    ng = int'(wr_gnt_o) + int'(rd_gnt_o) + int'(p_gnt_o);
    if (ng != 0) begin
      chk("gnt_onehot", ng, 1);
      who = rd_gnt_o ? 1 : p_gnt_o ? 2 : 0;
      if (gq.size() == 0) chk("gnt_unexpected", who, 3);
      else begin
        g = gq.pop_front();
        chk("gnt_who", who, g.who);
        chk("mem_en", mem_en_o, 1);
        chk("mem_we", mem_we_o, g.we);
        chk("mem_addr", mem_addr_o, g.addr);
        chk("mem_wstrb", mem_wstrb_o, g.strb);
        if (g.we) chk("mem_wdata", mem_wdata_o, g.wdata);
      end
      if (hold && gap_ref >= 0) chk("gnt_gap", cyc - gap_ref, 2);
      gap_ref = cyc;
      last_gnt = cyc;
      if (hold && gq.size() == 0) begin
        wr_req_i = 0; p_req_i = 0; hold = 0;
      end else if (!hold) begin
        if (who == 0) wr_req_i = 0;
        if (who == 1) rd_req_i = 0;
        if (who == 2) p_req_i = 0;
      end
    end else chk("idle_mem", {mem_en_o, mem_we_o, mem_wstrb_o}, 0);
    nv = int'(rd_rvalid_o) + int'(p_rvalid_o);
    if (nv != 0) begin
      chk("rv_onehot", nv, 1);
      who = rd_rvalid_o ? 1 : 2;
      if (rq.size() == 0) chk("rv_unexpected", who, 0);
      else begin
        r = rq.pop_front();
        chk("rv_who", who, r.who);
        chk("rv_data", rd_rvalid_o ? rd_rdata_o : p_rdata_o, r.data);
      end
      last_rv = cyc;
    end
  endtask

  task automatic run(input int max);
    for (int i = 0; i < max && (gq.size() != 0 || rq.size() != 0); i++) tick();
    chk("drain", gq.size() + rq.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    idle(3);
    chk("rst_pulses", {wr_gnt_o, rd_gnt_o, p_gnt_o, rd_rvalid_o, p_rvalid_o, mem_en_o, mem_we_o, busy_o}, 0);
    chk("rst_cmd", {mem_addr_o, mem_wdata_o}, 0);
    chk("rst_rdata", {rd_rdata_o, p_rdata_o}, 0);
    rst_i = 0;
    idle(2);

    t0 = cyc;
    req_wr(32'h10, 32'hDEADBEEF, 4'hF);
    run(10);
    chk("wr_latency", last_gnt - t0, 1);
    tick();
    chk("wr_busy_after", busy_o, 0);

    t0 = cyc;
    req_rd(32'h10, 32'hDEADBEEF);
    run(10);
    chk("rd_gnt_latency", last_gnt - t0, 1);
    chk("rd_rv_latency", last_rv - t0, 3);
    idle(3);
    chk("rd_rdata_held", rd_rdata_o, 32'hDEADBEEF);
    chk("p_rdata_untouched", p_rdata_o, 0);

    rst_i = 1;
    req_wr(32'h24, 32'hA5A5A5A5, 4'h3);
    req_rd(32'h24, 32'h0000A5A5);
    req_p(1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    tick();
    rst_i = 0;
    run(30);
    req_wr(32'h24, 32'hA5A5A5A5, 4'h3);
    req_rd(32'h24, 32'h0000A5A5);
    req_p(1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    run(30);

    hold = 1;
    gap_ref = -1;
    req_wr(32'h30, 32'hCAFEF00D, 4'hF);
    req_p(1'b1, 32'h20, 32'h12345678, 32'h0);
    repeat (2) begin
      push_g(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
      push_g(2, 1'b1, 32'h20, 32'h12345678, 4'hF);
    end
    run(40);
    chk("hold_released", {wr_req_i, p_req_i}, 0);
    idle(2);

    p_op_i = 0; p_addr_i = 32'h20; p_req_i = 1;
    push_g(2, 1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    tick();
    chk("rdata_busy", busy_o, 1);
    rst_i = 1;
    tick();
    chk("rst_no_prvalid", p_rvalid_o, 0);
    chk("rst_p_rdata", p_rdata_o, 0);
    chk("rst_state_arb", busy_o, 0);
    rst_i = 0;
    idle(3);

    rd_addr_i = 32'h10; rd_req_i = 1;
    push_g(1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    req_rd(32'h10, 32'hDEADBEEF);
    req_p(1'b0, 32'h20, 32'h0, 32'h12345678);
    run(30);

    req_p(1'b0, 32'h20, 32'h0, 32'h12345678);
    tick();
    rd_addr_i = 32'h10; rd_req_i = 1;
    tick();
    rd_req_i = 0;
    run(20);
    idle(5);
    req_rd(32'h24, 32'h0000A5A5);
    run(20);
    idle(3);
    chk("final_rdata", rd_rdata_o, 32'h0000A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single access port of the shared slave memory between three requesters: the AXI-Lite slave write path, the AXI-Lite slave read path, and the peripheral port.
- Sits between axi_control_s / the peripheral and mem_p.
- Uses round-robin arbitration and a latched command register, with a 3-state FSM that sequences each access and returns synchronous-read data to the winning requester.

Parameters:
ADDR_W, 32, address width of all requesters and the memory port
DATA_W, 32, data width; must be a multiple of 8; strobe width is DATA_W/8

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
wr_req_i  in  1  AXI write request; held until wr_gnt_o
wr_addr_i  in  ADDR_W  AXI write address
wr_data_i  in  DATA_W  AXI write data
wr_strb_i  in  DATA_W/8  AXI write byte strobes
wr_gnt_o  out  1  one-cycle pulse: write performed this cycle
rd_req_i  in  1  AXI read request; held until rd_gnt_o
rd_addr_i  in  ADDR_W  AXI read address
rd_gnt_o  out  1  one-cycle pulse: read issued to memory
rd_rvalid_o  out  1  one-cycle pulse: rd_rdata_o valid
rd_rdata_o  out  DATA_W  AXI read data, held until next AXI read completes
p_req_i  in  1  peripheral request; held until p_gnt_o
p_op_i  in  1  peripheral op: 1 = write, 0 = read
p_addr_i  in  ADDR_W  peripheral address
p_wdata_i  in  DATA_W  peripheral write data (full word)
p_gnt_o  out  1  one-cycle pulse: peripheral access issued
p_rvalid_o  out  1  one-cycle pulse: p_rdata_o valid (reads only)
p_rdata_o  out  DATA_W  peripheral read data, held until next peripheral read completes
mem_en_o  out  1  memory access enable
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_wstrb_o  out  DATA_W/8  memory byte strobes
mem_rdata_i  in  DATA_W  memory read data, valid one cycle after mem_en_o with mem_we_o = 0
busy_o  out  1  high in any state other than ARB

Behaviour:
- Requester indices: 0 = AXI write, 1 = AXI read, 2 = peripheral. A request is active when its req input is 1 in ARB.
- FSM states: ARB, ACCESS, RDATA.
- ARB:
  - If no request is active, stay in ARB.
  - Otherwise pick a winner by round-robin starting from pointer rr_ptr (2 bits, values 0..2). Latch the winner's index, we, addr, wdata and strb into the command register, then go to ACCESS.
  - Latched we/strb per winner: write path we = 1, strb = wr_strb_i. Read path we = 0, strb = 0. Peripheral we = p_op_i, strb = all-ones if write else 0.
- ACCESS (exactly one cycle):
  - mem_en_o = 1; mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o come from the command register.
  - Assert the winner's gnt pulse.
  - rr_ptr <= (winner + 1) mod 3.
  - If we = 1, go to ARB; else go to RDATA.
- RDATA (one cycle):
  - Sample mem_rdata_i into rd_rdata_o (winner 1) or p_rdata_o (winner 2).
  - Pulse the matching rvalid on the same edge the data register loads, i.e. rvalid is high during the cycle after RDATA.
  - Go to ARB.
- Latency:
  - Write: req seen in ARB at cycle N; gnt and memory write at N+1.
  - Read: gnt at N+1, rvalid/data at N+3.
  - Maximum rates: one write per 2 cycles, one read per 3 cycles.
- Outside ACCESS: mem_en_o = 0, mem_we_o = 0, mem_wstrb_o = 0. mem_addr_o/mem_wdata_o hold the command register value.
- Reset values: state = ARB, rr_ptr = 0, command register 0, all gnt/rvalid/mem_en/mem_we = 0, rd_rdata_o = 0, p_rdata_o = 0, busy_o = 0.
- Simultaneous requests: strict round-robin from rr_ptr; a requester that was just served has the lowest priority next arbitration. No requester waits more than 2 other grants.
- Req deasserted before latching: the request is not considered. Req deasserted after latching: the command still completes (gnt/rvalid are still generated).
- Inputs other than the latched requester's are ignored outside ARB; a new request arriving in ACCESS or RDATA is evaluated at the next ARB cycle.
- Reset mid-operation (any state): the next state is ARB, with no gnt or rvalid and no memory write issued in that cycle. Reset dominates all other events.
- The block has no arithmetic on data or addresses; they pass through unmodified.

Test Plan:
- Single AXI write addr 0x10, data 0xDEADBEEF, strb 0xF → wr_gnt_o one cycle after req; mem_we_o = 1, mem_addr_o = 0x10, mem_wstrb_o = 0xF for exactly that cycle; busy_o back to 0 next cycle.
- AXI read addr 0x10 with memory returning 0xDEADBEEF → rd_gnt_o at +1, rd_rvalid_o at +3, rd_rdata_o = 0xDEADBEEF held afterwards; p_rvalid_o stays 0.
- All three reqs asserted and held from reset → grant order write, read, peripheral. A second round with all reqs re-asserted → order write, read, peripheral again (rr_ptr wrapped to 0).
- Peripheral write (p_op_i = 1, addr 0x20, data 0x12345678) held continuously with AXI write held continuously → grants alternate write/peripheral every 2 cycles; peripheral mem_wstrb_o = 0xF.
- rst_i asserted during RDATA of a peripheral read → no p_rvalid_o, p_rdata_o = 0, state ARB, rr_ptr = 0 after release.
- AXI read req pulsed for one cycle while the peripheral access is in ACCESS → never granted. A read req held through latching then dropped → still completes with rd_rvalid_o.
